uart_host_link: RTL and testbench

Host-side serial endpoint that sits opposite the CPU's on-chip UART. It drives the CPU `serial_in` line and listens on the CPU `serial_out` line. Bytes pushed on a valid/ready byte interface are serialized as 8N1 frames. Frames arriving from the CPU are deserialized into a receive FIFO. It is used as the host/loader agent in system benches and on the FPGA debug harness, so it speaks exactly the same frame format and baud derivation as the CPU's UART.

---
 rtl/uart_host_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_host_link.sv | 200 ++++++++++++++++++++
 tb/tb_uart_host_link.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// Shared types and baud-timing helpers for the host-side UART endpoint.
package uart_host_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int calc_symbol(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int calc_half(input int clock_freq, input int baud_rate);
        return calc_symbol(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Empty reads as zero so the head is deterministic straight out of reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_host_link.sv
// Host-side 8N1 UART endpoint: byte-stream TX serializer and RX deserializer with FIFOs.
module uart_host_link #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       serial_out,
    input  logic       serial_in,
    output logic       rx_overflow,
    output logic       frame_error
);

    import uart_host_pkg::*;

    localparam int SYMBOL = calc_symbol(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF   = calc_half(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = $clog2(SYMBOL);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    tx_state_t     r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_serial_out;

    rx_state_t     r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_overflow;
    logic          r_frame_error;

    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;
    logic       w_tx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_push;
    logic       w_rx_pop;

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign serial_out  = r_serial_out;
    assign rx_overflow = r_rx_overflow;
    assign frame_error = r_frame_error;

    assign w_tx_pop  = !w_tx_empty &&
                       ((r_tx_state == TX_IDLE) ||
                        (r_tx_state == TX_STOP && r_tx_cnt == SYM_LAST));
    assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_cnt == SYM_LAST) && r_rx_sync;
    assign w_rx_pop  = rx_ready && !w_rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_valid && !w_tx_full),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (rx_ready),
        .o_data  (rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // TX: the line level is registered from the state, so it trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_serial_out <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_START: r_serial_out <= 1'b0;
                TX_DATA:  r_serial_out <= r_tx_shift[r_tx_bit];
                default:  r_serial_out <= 1'b1;
            endcase
            if (w_tx_pop) r_tx_shift <= w_tx_head;
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_tx_empty) begin
                        r_tx_state <= TX_START;
                        r_tx_cnt   <= '0;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == SYM_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == SYM_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
                        else                  r_tx_bit   <= r_tx_bit + 3'd1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == SYM_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= w_tx_empty ? TX_IDLE : TX_START;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX: synchronizer resets high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_overflow <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_meta <= serial_in;
            r_rx_sync <= r_rx_meta;
            if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_overflow <= 1'b1;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == SYM_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == SYM_LAST) begin
                        r_rx_cnt <= '0;
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_rx_state    <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (r_rx_sync) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_link.sv
// Bench for uart_host_link: frame-schedule model for the TX line, byte-queue model for RX.
module tb_uart_host_link;

    localparam int SYM  = 434;
    localparam int HALF = 217;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       serial_out;
    logic       serial_in;
    logic       rx_overflow;
    logic       frame_error;
    logic       line_drv;
    logic       loopback;

    assign serial_in = loopback ? serial_out : line_drv;

    always #5 clk = ~clk;

    uart_host_link #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .serial_out  (serial_out),
        .serial_in   (serial_in),
        .rx_overflow (rx_overflow),
        .frame_error (frame_error)
    );

    int         n_tests;
    int         n_fail;
    longint     e;
    longint     last_end;
    longint     fr_start [$];
    longint     fr_push  [$];
    logic [7:0] fr_byte  [$];
    logic [7:0] rxq      [$];
    logic [7:0] popped   [$];
    bit         exp_ovf;
    bit         exp_ferr;
    bit         in_inject;

    task automatic note_fail();
        n_fail++;
        if (n_fail >= 40) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            $display("FAIL %s: got %b, want %b (edge %0d)", name, act, exp, e);
            note_fail();
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            $display("FAIL %s: got %02h, want %02h (edge %0d)", name, act, exp, e);
            note_fail();
        end
    endtask

    task automatic model_rx_push(input logic [7:0] b);
        if (rxq.size() < 8) rxq.push_back(b);
        else                exp_ovf = 1'b1;
    endtask

    // Called once per cycle at the falling edge: state observed is that after edge e.
    task automatic monitor();
        int     occ;
        int     idx;
        logic   exp_so;
        longint s;
        bit     busy;
        e++;
        while (fr_start.size() > 0 && e >= fr_start[0] + 10 * SYM) begin
            if (loopback) model_rx_push(fr_byte[0]);
            void'(fr_start.pop_front());
            void'(fr_push.pop_front());
            void'(fr_byte.pop_front());
        end
        exp_so = 1'b1;
        occ    = 0;
        foreach (fr_start[i]) begin
            if (e >= fr_start[i] && e < fr_start[i] + 10 * SYM) begin
                idx = int'((e - fr_start[i]) / SYM);
                if (idx == 0)      exp_so = 1'b0;
                else if (idx <= 8) exp_so = fr_byte[i][idx-1];
            end
            if (fr_push[i] <= e && fr_start[i] - 1 > e) occ++;
        end
        chk1("serial_out", serial_out, exp_so);
        chk1("tx_ready", tx_ready, occ < 8);

        busy = in_inject || (loopback && fr_start.size() > 0);
        if (rxq.size() > 0) begin
            chk1("rx_valid_held", rx_valid, 1'b1);
            chk8("rx_data_head", rx_data, rxq[0]);
        end else if (!busy) begin
            chk1("rx_valid_empty", rx_valid, 1'b0);
        end
        if (!busy) begin
            chk1("rx_overflow", rx_overflow, exp_ovf);
            chk1("frame_error", frame_error, exp_ferr);
        end else begin
            if (exp_ovf)  chk1("rx_overflow_sticky", rx_overflow, 1'b1);
            if (exp_ferr) chk1("frame_error_sticky", frame_error, 1'b1);
        end

        if (!rst && rx_valid && rx_ready) begin
            chk1("rx_pop_expected", rxq.size() > 0, 1'b1);
            if (rxq.size() > 0) begin
                popped.push_back(rx_data);
                void'(rxq.pop_front());
            end
        end

        if (!rst && tx_valid && tx_ready) begin
            s = (e + 3 > last_end) ? e + 3 : last_end;
            fr_start.push_back(s);
            fr_push.push_back(e + 1);
            fr_byte.push_back(tx_data);
            last_end = s + 10 * SYM;
        end

        if (rst) begin
            fr_start.delete();
            fr_push.delete();
            fr_byte.delete();
            rxq.delete();
            last_end = 0;
            exp_ovf  = 1'b0;
            exp_ferr = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [7:0] b, input logic good);
        in_inject = 1'b1;
        line_drv  = 1'b0;
        repeat (SYM) tick();
        for (int k = 0; k < 8; k++) begin
            line_drv = b[k];
            repeat (SYM) tick();
        end
        line_drv = good;
        repeat (SYM) tick();
        line_drv = 1'b1;
        if (!good) repeat (SYM) tick();
        if (good) model_rx_push(b);
        else      exp_ferr = 1'b1;
        in_inject = 1'b0;
    endtask

    task automatic drain(input int n);
        popped.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 50 && popped.size() < n; i++) tick();
        rx_ready = 1'b0;
        chk8("drain_count", 8'(popped.size()), 8'(n));
    endtask

    logic [7:0] b;
    logic [7:0] lb [4];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        e         = 0;
        last_end  = 0;
        exp_ovf   = 1'b0;
        exp_ferr  = 1'b0;
        in_inject = 1'b0;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        line_drv  = 1'b1;
        loopback  = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        chk1("rst_serial_out", serial_out, 1'b1);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk8("rst_rx_data", rx_data, 8'h00);
        chk1("rst_rx_overflow", rx_overflow, 1'b0);
        chk1("rst_frame_error", frame_error, 1'b0);

        // Single frame 0xA5 on the line
        tick();
        b        = 8'hA5;
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        chk1("a5_before_start", serial_out, 1'b1);
        tick();
        chk1("a5_start_first", serial_out, 1'b0);
        repeat (SYM - 1) tick();
        chk1("a5_start_last", serial_out, 1'b0);
        tick();
        chk1("a5_bit0_first", serial_out, 1'b1);
        repeat (HALF) tick();
        for (int k = 0; k < 9; k++) begin
            chk1("a5_mid_bit", serial_out, (k < 8) ? b[k] : 1'b1);
            repeat (SYM) tick();
        end
        chk1("a5_idle_after", serial_out, 1'b1);

        // Loopback of four back-to-back frames
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h55;
        lb[3] = 8'h0D;
        loopback = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data  = lb[i];
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        repeat (4 * 10 * SYM + 50) tick();
        loopback = 1'b0;
        drain(4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size()) chk8("lb_byte", popped[i], lb[i]);
        chk1("lb_overflow", rx_overflow, 1'b0);
        chk1("lb_frame_error", frame_error, 1'b0);

        // Overflow: nine frames into an eight-deep FIFO
        for (int v = 1; v <= 9; v++) inject(8'(v), 1'b1);
        repeat (5) tick();
        chk1("ovf_flag", rx_overflow, 1'b1);
        chk1("ovf_rx_valid", rx_valid, 1'b1);
        chk8("ovf_head", rx_data, 8'h01);
        drain(8);
        for (int i = 0; i < 8; i++)
            if (i < popped.size()) chk8("ovf_byte", popped[i], 8'(i + 1));
        tick();
        chk1("ovf_drained", rx_valid, 1'b0);

        // Frame error then a good frame
        inject(8'h3C, 1'b0);
        chk1("ferr_flag", frame_error, 1'b1);
        chk1("ferr_no_push", rx_valid, 1'b0);
        inject(8'h41, 1'b1);
        drain(1);
        if (popped.size() > 0) chk8("ferr_next_byte", popped[0], 8'h41);
        chk1("ferr_sticky", frame_error, 1'b1);
        chk1("ovf_sticky", rx_overflow, 1'b1);

        // Glitch after a reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk1("rst2_overflow", rx_overflow, 1'b0);
        chk1("rst2_frame_error", frame_error, 1'b0);
        in_inject = 1'b1;
        line_drv  = 1'b0;
        repeat (100) tick();
        line_drv = 1'b1;
        repeat (600) tick();
        in_inject = 1'b0;
        tick();
        chk1("glitch_rx_valid", rx_valid, 1'b0);
        chk1("glitch_overflow", rx_overflow, 1'b0);
        chk1("glitch_frame_error", frame_error, 1'b0);

        // Reset in the middle of a TX start bit, then a clean frame
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (100) tick();
        chk1("midtx_low", serial_out, 1'b0);
        rst = 1'b1;
        tick();
        chk1("midtx_rst_high", serial_out, 1'b1);
        chk1("midtx_rst_ready", tx_ready, 1'b1);
        rst = 1'b0;
        repeat (3) tick();
        chk1("midtx_stays_high", serial_out, 1'b1);
        loopback = 1'b1;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (10 * SYM + 50) tick();
        loopback = 1'b0;
        drain(1);
        if (popped.size() > 0) chk8("fresh_byte", popped[0], 8'hC3);
        chk1("fresh_frame_error", frame_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
